uart_tx_top: RTL and testbench

//   8N1 UART transmitter. Serialises one byte per tx_start request onto tx_pin
//   as: start bit, 8 data bits LSB-first, stop bit. Reference use: clk = 19200 Hz,
//   i.e. 2x the 9600 baud line rate. Top-level block driving the board TX pin.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_top_baud.sv | 30 +++
 rtl/uart_tx_top.sv | 91 +++++++++
 tb/tb_uart_tx_top.sv | 133 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_top_baud.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses o_tick on the last count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clear)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_top.sv
// 8N1 UART transmitter: start bit, DATA_BITS data bits LSB first, stop bit.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] byte2send,
  input  logic                 tx_start,
  output logic                 tx_done,
  output logic                 tx_pin
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [IW-1:0]        r_idx;
  logic                 r_tx_pin;
  logic                 r_tx_done;
  logic [IW-1:0]        w_next_idx;
  logic                 w_tick;
  logic                 w_idle;

  assign w_idle     = (r_state == IDLE);
  assign w_next_idx = r_idx + 1'b1;
  assign tx_pin     = r_tx_pin;
  assign tx_done    = r_tx_done;

  // Counter is held at zero while idle, so every frame starts on a fresh bit period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_clear(w_idle),
    .i_en   (!w_idle),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_idx     <= '0;
      r_tx_pin  <= LINE_IDLE;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_pin <= LINE_IDLE;
          if (tx_start) begin
            r_shreg  <= byte2send;
            r_state  <= START;
            r_tx_pin <= START_BIT;
          end
        end
        START: begin
          if (w_tick) begin
            r_state  <= DATA;
            r_idx    <= '0;
            r_tx_pin <= r_shreg[0];
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_idx == LAST_IDX) begin
              r_state  <= STOP;
              r_tx_pin <= STOP_BIT;
            end else begin
              r_idx    <= w_next_idx;
              r_tx_pin <= r_shreg[w_next_idx];
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            r_state   <= IDLE;
            r_tx_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top; per-cycle line/done expectations are queued at send time.
module tb_uart_tx_top;

  localparam int CPB = 2;
  localparam int DB  = 8;

  typedef struct packed {
    logic pin;
    logic done;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_start;
  logic [DB-1:0] byte2send;
  logic          tx_done;
  logic          tx_pin;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  uart_tx_top #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .byte2send(byte2send),
    .tx_start (tx_start),
    .tx_done  (tx_done),
    .tx_pin   (tx_pin)
  );

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: sample just after the edge and compare with the scoreboard head (idle if empty).
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) e = q.pop_front();
    else              e = exp_t'{pin: 1'b1, done: 1'b0};
    chk("tx_pin", tx_pin, e.pin);
    chk("tx_done", tx_done, e.done);
  endtask

  // Samples after the accepting edge: start, data LSB first, stop, then the done cycle.
  task automatic push_frame(input logic [DB-1:0] b);
    for (int k = 0; k < CPB; k++) q.push_back(exp_t'{pin: 1'b0, done: 1'b0});
    for (int i = 0; i < DB; i++)
      for (int k = 0; k < CPB; k++) q.push_back(exp_t'{pin: b[i], done: 1'b0});
    for (int k = 0; k < CPB; k++) q.push_back(exp_t'{pin: 1'b1, done: 1'b0});
    q.push_back(exp_t'{pin: 1'b1, done: 1'b1});
  endtask

  task automatic send(input logic [DB-1:0] b);
    byte2send = b;
    tx_start  = 1'b1;
    push_frame(b);
    cyc();
    tx_start = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    tx_start  = 1'b0;
    byte2send = '0;

    // Reset and quiet idle
    repeat (3) cyc();
    rst = 1'b0;
    repeat (4) cyc();

    // Reference byte
    send(8'b1001_1010);
    repeat (22) cyc();

    // All-zero and all-one data
    send(8'h00);
    repeat (21) cyc();
    send(8'hFF);
    repeat (22) cyc();

    // Mid-frame byte change and start request are ignored
    send(8'h3C);
    repeat (5) cyc();
    byte2send = 8'hFF;
    tx_start  = 1'b1;
    repeat (3) cyc();
    tx_start  = 1'b0;
    byte2send = 8'h00;
    repeat (16) cyc();

    // Held start: second frame accepted on the done cycle's edge
    byte2send = 8'hA5;
    tx_start  = 1'b1;
    push_frame(8'hA5);
    push_frame(8'hA5);
    repeat (22) cyc();
    tx_start = 1'b0;
    repeat (22) cyc();

    // Reset during data bit 3 (bit 3 of 0xA5 is 0, so the line visibly returns high)
    send(8'hA5);
    repeat (8) cyc();
    chk("pre_rst_bit3", tx_pin, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_async_pin", tx_pin, 1'b1);
    chk("rst_async_done", tx_done, 1'b0);
    q.delete();
    repeat (3) cyc();
    rst = 1'b0;
    repeat (25) cyc();

    // Normal frame after reset release
    send(8'h96);
    repeat (22) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
